// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 matrix keypad column scanner. It debounces one key press and
//            its release, then presents a one-hot {row, col} pair with a
//            single-cycle acceptance strobe.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int                 c_DIV_W      = $clog2(SCAN_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE    = c_DIV_W'(1);
  localparam logic [3:0]         c_DEB_TARGET = 4'(DEBOUNCE_CNT);
  // A single-tick debounce accepts (or releases) on the detecting tick itself.
  localparam bit                 c_ACCEPT_NOW = (DEBOUNCE_CNT == 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_s;
  logic [c_DIV_W-1:0] r_div;
  state_t             r_state;
  logic [3:0]         r_col;
  logic [3:0]         r_cand_row;
  logic [3:0]         r_cand_col;
  logic [3:0]         r_cnt;
  logic [3:0]         r_key_row;
  logic [3:0]         r_key_col;
  logic               r_strobe;
  logic               r_held;

  logic               w_tick;
  logic [3:0]         w_rot;
  logic               w_row_onehot;
  logic               w_match;
  logic [3:0]         w_cnt_inc;
  logic               w_cnt_done;

  assign w_tick       = (r_div == c_DIV_LAST);
  assign w_rot        = {r_col[2:0], r_col[3]};
  // Exactly one row line high; ghosting or multi-key patterns are rejected.
  assign w_row_onehot = (r_row_s != 4'd0) && ((r_row_s & (r_row_s - 4'd1)) == 4'd0);
  assign w_match      = (r_row_s == r_cand_row);
  assign w_cnt_inc    = r_cnt + 4'd1;
  assign w_cnt_done   = (w_cnt_inc == c_DEB_TARGET);

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'd0;
      r_row_s    <= 4'd0;
    end else begin
      r_row_meta <= row_in;
      r_row_s    <= r_row_meta;
    end
  end

  // Free-running dwell divider; its last count is the scan tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_ONE;
    end
  end

  // Scan / debounce / hold / release sequencer, advancing only on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_SCAN;
      r_col      <= 4'b0001;
      r_cand_row <= 4'd0;
      r_cand_col <= 4'd0;
      r_cnt      <= 4'd0;
      r_key_row  <= 4'd0;
      r_key_col  <= 4'd0;
      r_strobe   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_row_onehot) begin
              r_cand_row <= r_row_s;
              r_cand_col <= r_col;
              if (c_ACCEPT_NOW) begin
                r_key_row <= r_row_s;
                r_key_col <= r_col;
                r_strobe  <= 1'b1;
                r_held    <= 1'b1;
                r_cnt     <= 4'd0;
                r_state   <= ST_PRESSED;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= ST_DEBOUNCE;
              end
            end else begin
              r_col <= w_rot;
            end
          end

          ST_DEBOUNCE: begin
            if (w_match) begin
              if (w_cnt_done) begin
                r_key_row <= r_cand_row;
                r_key_col <= r_cand_col;
                r_strobe  <= 1'b1;
                r_held    <= 1'b1;
                r_cnt     <= 4'd0;
                r_state   <= ST_PRESSED;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt   <= 4'd0;
              r_col   <= w_rot;
              r_state <= ST_SCAN;
            end
          end

          ST_PRESSED: begin
            if (!w_match) begin
              if (c_ACCEPT_NOW) begin
                r_held  <= 1'b0;
                r_cnt   <= 4'd0;
                r_col   <= w_rot;
                r_state <= ST_SCAN;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= ST_RELEASE;
              end
            end
          end

          ST_RELEASE: begin
            if (!w_match) begin
              if (w_cnt_done) begin
                r_held  <= 1'b0;
                r_cnt   <= 4'd0;
                r_col   <= w_rot;
                r_state <= ST_SCAN;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Key came back before release was confirmed: still the same press.
              r_cnt   <= 4'd0;
              r_state <= ST_PRESSED;
            end
          end

          default: begin
            r_cnt   <= 4'd0;
            r_col   <= 4'b0001;
            r_state <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign col_drive  = r_col;
  assign key_row    = r_key_row;
  assign key_col    = r_key_col;
  assign key_strobe = r_strobe;
  assign key_held   = r_held;

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Sequencer for the 4x4 matrix keypad. It drives one column at a time, samples the row lines, debounces a single-key press and release, and presents a stable one-hot {row, col} pair plus a one-cycle strobe. The key_row/key_col outputs feed the keypad decoder directly, which turns them into a 4-bit key value. Sits between the keypad pins and the decoder/LCD entry logic.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven (dwell); one "tick" per dwell; legal >= 4
DEBOUNCE_CNT, 4, consecutive ticks required to accept a press and to accept a release; legal 1..15

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
row_in  input  4  raw keypad row lines, active-high, asynchronous to clk
col_drive  output  4  one-hot column drive to keypad
key_row  output  4  one-hot row of the accepted key (to decoder row)
key_col  output  4  one-hot column of the accepted key (to decoder col)
key_strobe  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high from acceptance until release is accepted

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: col_drive=0001, key_row=0000, key_col=0000, key_strobe=0, key_held=0, state=SCAN, divider=0, debounce counter=0, synchroniser flops=0.
- row_in passes through a 2-flop synchroniser into row_s. All decisions use row_s.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick=1 when the count equals SCAN_DIV-1. The divider runs freely in every state.
- States: SCAN, DEBOUNCE, PRESSED, RELEASE. All transitions below happen only on tick cycles; non-tick cycles hold state.
- SCAN:
  - row_s==0000: rotate col_drive 0001->0010->0100->1000->0001.
  - row_s is exactly one-hot: capture cand_row=row_s and cand_col=col_drive, set cnt=1, go to DEBOUNCE. col_drive freezes.
  - row_s has more than one bit set (ghost or multi-key): ignore it and rotate as for 0000.
- DEBOUNCE:
  - row_s==cand_row: increment cnt. When cnt reaches DEBOUNCE_CNT, load key_row=cand_row and key_col=cand_col, pulse key_strobe, set key_held=1, go to PRESSED.
  - Any other value: cnt=0, return to SCAN, rotate col_drive. Nothing is emitted.
  - With DEBOUNCE_CNT=1, acceptance occurs on the same tick as detection (SCAN goes straight to PRESSED).
- PRESSED: col_drive stays frozen on cand_col.
  - row_s!=cand_row: cnt=1, go to RELEASE.
  - Otherwise stay. A key held any length yields only one strobe (no auto-repeat).
- RELEASE:
  - row_s!=cand_row: increment cnt. When cnt reaches DEBOUNCE_CNT, key_held=0, cnt=0, go to SCAN, rotate col_drive.
  - row_s==cand_row: cnt=0, return to PRESSED. No new strobe.
- key_strobe is registered and asserts the cycle after the accepting tick, for exactly 1 cycle. key_row/key_col update in that same cycle and hold until the next acceptance. They are not cleared on release.
- Press latency: first detecting tick + (DEBOUNCE_CNT-1) ticks + 1 cycle, plus 2 synchroniser cycles from the pin.
- Reset asserted mid-operation (any state): all outputs return to reset values immediately, with no strobe. Scanning restarts at column 0001.
- col_drive is always exactly one-hot after reset.

Test Plan:
Bench keypad model: row_in = pressed_row when col_drive==pressed_col, else 0000. All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Idle rotation: release reset, no key -> col_drive 0001, then 0010 after 4 clks, 0100 after 8, 1000 after 12, 0001 after 16; key_strobe never asserts.
2. Clean press: hold row 0100 / col 0010 for 40 clks -> exactly one key_strobe with key_row=0100, key_col=0010 (decoder value 9); key_held=1; col_drive stays 0010 while held.
3. Bounce: row 0001 / col 0001 present for 1 tick, then absent, then present for 2 ticks -> no strobe; rotation resumes after each abort.
4. Release with glitch: after scenario 2, drop the row for 2 ticks, restore for 1 tick, then drop for 3 ticks -> no extra strobe; key_held falls only after the 3-tick drop; rotation resumes from col 0100; key_row/key_col still read 0100/0010.
5. Multi-key: row_s=0110 while col 0100 is driven -> treated as no key, rotation continues, no strobe.
6. Reset mid-DEBOUNCE and mid-PRESSED: assert rst asynchronously between clk edges -> outputs go to reset values without waiting for an edge; no strobe; col_drive=0001 on the first tick after reset is released.
